// File: rtl/fire_control.sv
// Fire-key to shot-strobe generator with per-shot cooldown and a finite magazine that reloads on a frame timer.
// Optional FIRE_AUTOREPEAT_EN: while the key is held, shots repeat every REPEAT_FRAMES frames.
module fire_control #(
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAGAZINE        = 7,
  parameter int RELOAD_FRAMES   = 60,
  parameter int REPEAT_FRAMES   = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       fire_key,
  input  logic       startOfFrame,
  input  logic       enable,
  output logic       shooting_pulse,
  output logic [3:0] ammo_count,
  output logic       reloading
);

  // state    | meaning
  // S_READY  | a shot may be issued
  // S_COOLDN | counting frames down after a shot
  // S_RELOAD | counting frames down with an empty magazine
  typedef enum logic [1:0] {S_READY, S_COOLDN, S_RELOAD} state_t;

  localparam int MAX_A = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES;
  localparam int MAX_F = (MAX_A > REPEAT_FRAMES) ? MAX_A : REPEAT_FRAMES;
  localparam int CW    = $clog2(MAX_F + 1);

  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] RL_LOAD  = CW'(RELOAD_FRAMES);
  localparam logic [3:0]    MAG_LOAD = 4'(MAGAZINE);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_dec;
  logic [3:0]    r_ammo, w_ammo_nxt;
  logic          r_key_d;
  logic          r_pulse;
  logic          w_press;
  logic          w_repeat;
  logic          w_fire;

  assign w_press = fire_key & ~r_key_d;

`ifdef FIRE_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LOAD = CW'(REPEAT_FRAMES);
  logic [CW-1:0] r_rep;

  // Held key counts frames down; releasing or shooting restarts the period.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rep <= REP_LOAD;
    end else if (w_fire || !fire_key) begin
      r_rep <= REP_LOAD;
    end else if (startOfFrame && (r_rep != '0)) begin
      r_rep <= r_rep - 1'b1;
    end
  end

  assign w_repeat = fire_key & (r_rep == '0);
`else
  assign w_repeat = 1'b0;
`endif

  assign w_fire = (r_state == S_READY) & enable & (r_ammo != 4'd0) & (w_press | w_repeat);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ammo_nxt  = r_ammo;
    w_cnt_dec   = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    case (r_state)
      S_READY: begin
        // A fire outranks a coincident frame pulse, so that frame is not counted.
        if (w_fire) begin
          w_ammo_nxt  = r_ammo - 4'd1;
          w_cnt_nxt   = CD_LOAD;
          w_state_nxt = S_COOLDN;
        end
      end
      S_COOLDN: begin
        if (startOfFrame) begin
          w_cnt_nxt = w_cnt_dec;
          if (w_cnt_dec == '0) begin
            if (r_ammo != 4'd0) begin
              w_state_nxt = S_READY;
            end else begin
              w_cnt_nxt   = RL_LOAD;
              w_state_nxt = S_RELOAD;
            end
          end
        end
      end
      S_RELOAD: begin
        if (startOfFrame) begin
          w_cnt_nxt = w_cnt_dec;
          if (w_cnt_dec == '0) begin
            w_ammo_nxt  = MAG_LOAD;
            w_state_nxt = S_READY;
          end
        end
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  // key_d resets high so a key held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_READY;
      r_cnt   <= '0;
      r_ammo  <= MAG_LOAD;
      r_key_d <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ammo  <= w_ammo_nxt;
      r_key_d <= fire_key;
      r_pulse <= w_fire;
    end
  end

  assign shooting_pulse = r_pulse;
  assign ammo_count     = r_ammo;
  assign reloading      = (r_state == S_RELOAD);

endmodule
